ahb_lite_master_port: RTL and testbench

//  AHB-Lite initiator that turns a simple command/response interface into single

---
 rtl/ahb_lite_master_port.sv | 233 +++++++++++++++++++++++
 tb/tb_ahb_lite_master_port.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : ahb_lite_master_port
//  Purpose  : AHB-Lite initiator that turns a command/response handshake into
//             single NONSEQ transfers. Non-pipelined: at most one transfer is
//             outstanding. There are no bursts and no locked transfers.
//  Ports    : HCLK/HRESETn            - bus clock, async active-low reset
//             cmd_*                   - command request (valid/ready handshake)
//             rsp_*                   - one-cycle response pulse, no backpressure
//             bus_hang                - sticky data-phase watchdog flag
//             H* (out)                - AHB-Lite master address/data/control
//             HREADY/HRDATA/HRESP     - AHB-Lite slave response
//  Revision : 1.0 - initial release
// ============================================================================
module ahb_lite_master_port #(
    parameter logic [3:0]  HPROT_VAL   = 4'b0011,
    parameter int unsigned WDOG_CYCLES = 255
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    // command side
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [2:0]  cmd_size,
    input  logic [31:0] cmd_wdata,
    // response side
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_rdata,
    output logic        bus_hang,
    // AHB-Lite master outputs
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic [2:0]  HSIZE,
    output logic        HWRITE,
    output logic [31:0] HWDATA,
    output logic [2:0]  HBURST,
    output logic        HMASTLOCK,
    output logic [3:0]  HPROT,
    // AHB-Lite slave response
    input  logic        HREADY,
    input  logic [31:0] HRDATA,
    input  logic        HRESP
);

    localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;

    // Counter is at least 8 bits and grows to hold any watchdog limit.
    localparam int unsigned c_CNT_W    = (WDOG_CYCLES > 255) ? $clog2(WDOG_CYCLES + 1) : 8;
    localparam logic [c_CNT_W-1:0] c_WDOG_LIM = c_CNT_W'(WDOG_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADDR = 2'd1,
        S_DATA = 2'd2,
        S_REJ  = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state;

    logic [31:0]        r_wdata;
    logic [c_CNT_W-1:0] r_cnt;

    logic [31:0]        w_haddr;
    logic [1:0]         w_htrans;
    logic [2:0]         w_hsize;
    logic               w_hwrite;
    logic [31:0]        w_hwdata;
    logic [31:0]        w_wdata;
    logic [c_CNT_W-1:0] w_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_hang;
    logic               w_rsp_valid;
    logic               w_rsp_err;
    logic [31:0]        w_rsp_rdata;
    logic               w_legal;
    logic [31:0]        w_lane_wdata;
    logic [31:0]        w_rd_shifted;
    logic [31:0]        w_rd_aligned;

    assign HBURST    = 3'b000;
    assign HMASTLOCK = 1'b0;
    assign HPROT     = HPROT_VAL;
    assign cmd_ready = (r_state == S_IDLE);

    // Only naturally aligned byte/halfword/word transfers reach the bus.
    always_comb begin
        w_legal = 1'b0;
        case (cmd_size)
            3'd0:    w_legal = 1'b1;
            3'd1:    w_legal = ~cmd_addr[0];
            3'd2:    w_legal = (cmd_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    // Replicate the right-justified write data across every byte lane so the
    // slave finds it on whichever lane the address selects.
    always_comb begin
        case (HSIZE)
            3'd0:    w_lane_wdata = {4{r_wdata[7:0]}};
            3'd1:    w_lane_wdata = {2{r_wdata[15:0]}};
            default: w_lane_wdata = r_wdata;
        endcase
    end

    // Bring the addressed lane down to bit 0 and zero-extend to the size.
    assign w_rd_shifted = HRDATA >> {HADDR[1:0], 3'b000};

    always_comb begin
        case (HSIZE)
            3'd0:    w_rd_aligned = {24'd0, w_rd_shifted[7:0]};
            3'd1:    w_rd_aligned = {16'd0, w_rd_shifted[15:0]};
            default: w_rd_aligned = w_rd_shifted;
        endcase
    end

    assign w_cnt_inc = (r_cnt == {c_CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;

    // Next-state and next-output logic.
    always_comb begin
        w_state     = r_state;
        w_haddr     = HADDR;
        w_htrans    = HTRANS;
        w_hsize     = HSIZE;
        w_hwrite    = HWRITE;
        w_hwdata    = HWDATA;
        w_wdata     = r_wdata;
        w_cnt       = r_cnt;
        w_hang      = bus_hang;
        w_rsp_valid = 1'b0;
        w_rsp_err   = 1'b0;
        w_rsp_rdata = 32'd0;

        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_wdata = cmd_wdata;
                    if (w_legal) begin
                        w_state  = S_ADDR;
                        w_htrans = c_HTRANS_NONSEQ;
                        w_haddr  = cmd_addr;
                        w_hsize  = cmd_size;
                        w_hwrite = cmd_write;
                    end else begin
                        // Rejected locally: answer next cycle, bus untouched.
                        w_state     = S_REJ;
                        w_rsp_valid = 1'b1;
                        w_rsp_err   = 1'b1;
                    end
                end
            end

            S_ADDR: begin
                if (HREADY) begin
                    w_state  = S_DATA;
                    w_htrans = c_HTRANS_IDLE;
                    w_hwdata = w_lane_wdata;
                    w_cnt    = '0;
                end
            end

            S_DATA: begin
                if (HREADY) begin
                    w_state     = S_IDLE;
                    w_rsp_valid = 1'b1;
                    w_rsp_err   = HRESP;
                    if (!HRESP && !HWRITE) begin
                        w_rsp_rdata = w_rd_aligned;
                    end
                    w_cnt = '0;
                end else begin
                    // The first cycle of a two-cycle ERROR also lands here
                    // and simply waits for the completing HREADY.
                    w_cnt = w_cnt_inc;
                    if ((WDOG_CYCLES != 0) && (w_cnt_inc >= c_WDOG_LIM)) begin
                        w_hang = 1'b1;
                    end
                end
            end

            S_REJ: begin
                w_state = S_IDLE;
            end

            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            HADDR     <= 32'd0;
            HTRANS    <= c_HTRANS_IDLE;
            HSIZE     <= 3'd0;
            HWRITE    <= 1'b0;
            HWDATA    <= 32'd0;
            r_wdata   <= 32'd0;
            r_cnt     <= '0;
            bus_hang  <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
        end else begin
            HADDR     <= w_haddr;
            HTRANS    <= w_htrans;
            HSIZE     <= w_hsize;
            HWRITE    <= w_hwrite;
            HWDATA    <= w_hwdata;
            r_wdata   <= w_wdata;
            r_cnt     <= w_cnt;
            bus_hang  <= w_hang;
            rsp_valid <= w_rsp_valid;
            rsp_err   <= w_rsp_err;
            rsp_rdata <= w_rsp_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_master_port.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ahb_lite_master_port
//  Purpose  : Self-checking bench for ahb_lite_master_port. A transaction-level
//             model predicts every output each cycle; directed tests pin
//             latency, read alignment, write lane replication, local
//             rejection, slave errors, the watchdog and mid-transfer reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ahb_lite_master_port;

    localparam int WDOG = 4;

    logic        HCLK    = 1'b0;
    logic        HRESETn = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr  = 32'd0;
    logic [2:0]  cmd_size  = 3'd0;
    logic [31:0] cmd_wdata = 32'd0;
    logic        HREADY = 1'b1;
    logic [31:0] HRDATA = 32'd0;
    logic        HRESP  = 1'b0;

    logic        cmd_ready, rsp_valid, rsp_err, bus_hang, HWRITE, HMASTLOCK;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_port #(
        .HPROT_VAL   (4'b0011),
        .WDOG_CYCLES (WDOG)
    ) dut (
        .HCLK      (HCLK),
        .HRESETn   (HRESETn),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_write (cmd_write),
        .cmd_addr  (cmd_addr),
        .cmd_size  (cmd_size),
        .cmd_wdata (cmd_wdata),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .rsp_rdata (rsp_rdata),
        .bus_hang  (bus_hang),
        .HADDR     (HADDR),
        .HTRANS    (HTRANS),
        .HSIZE     (HSIZE),
        .HWRITE    (HWRITE),
        .HWDATA    (HWDATA),
        .HBURST    (HBURST),
        .HMASTLOCK (HMASTLOCK),
        .HPROT     (HPROT),
        .HREADY    (HREADY),
        .HRDATA    (HRDATA),
        .HRESP     (HRESP)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model (transaction level) -------------------
    function automatic bit is_legal(input logic [31:0] a, input logic [2:0] s);
        return (s == 3'd0) || (s == 3'd1 && a % 2 == 0) || (s == 3'd2 && a % 4 == 0);
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] d, input logic [31:0] a,
                                           input logic [2:0] s);
        logic [63:0] v;
        logic [63:0] m;
        logic [63:0] r;
        v = {32'd0, d} >> (8 * (a % 4));
        m = (64'd1 << (8 << s)) - 64'd1;
        r = v & m;
        return r[31:0];
    endfunction

    function automatic logic [31:0] exp_wd(input logic [31:0] d, input logic [2:0] s);
        logic [31:0] b;
        logic [31:0] h;
        b = d % 256;
        h = d % 65536;
        if (s == 3'd0) return b * 32'h0101_0101;
        if (s == 3'd1) return h * 32'h0001_0001;
        return d;
    endfunction

    // phase of the one outstanding transaction: 0 none, 1 address, 2 data, 3 rejected
    int          m_phase = 0;
    int          m_waits = 0;
    logic [31:0] m_addr  = 32'd0;
    logic [31:0] m_wdata = 32'd0;
    logic [2:0]  m_size  = 3'd0;
    logic        m_write = 1'b0;
    logic        m_hang  = 1'b0;
    logic        m_rv    = 1'b0;
    logic        m_re    = 1'b0;
    logic [31:0] m_rd    = 32'd0;

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_phase = 0; m_waits = 0; m_hang = 1'b0;
            m_rv = 1'b0; m_re = 1'b0; m_rd = 32'd0;
        end else begin
            m_rv = 1'b0; m_re = 1'b0; m_rd = 32'd0;
            case (m_phase)
                0: if (cmd_valid) begin
                    if (is_legal(cmd_addr, cmd_size)) begin
                        m_phase = 1;
                        m_addr = cmd_addr; m_size = cmd_size;
                        m_write = cmd_write; m_wdata = cmd_wdata;
                    end else begin
                        m_phase = 3; m_rv = 1'b1; m_re = 1'b1;
                    end
                end
                1: if (HREADY) begin
                    m_phase = 2; m_waits = 0;
                end
                2: if (HREADY) begin
                    m_rv = 1'b1;
                    m_re = HRESP;
                    m_rd = (!m_write && !HRESP) ? exp_rd(HRDATA, m_addr, m_size) : 32'd0;
                    m_phase = 0;
                end else begin
                    m_waits++;
                    if (WDOG != 0 && m_waits >= WDOG) m_hang = 1'b1;
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge HCLK) begin
        chk("cmd_ready", 32'(cmd_ready), 32'(m_phase == 0));
        chk("HTRANS", 32'(HTRANS), (m_phase == 1) ? 32'd2 : 32'd0);
        chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        chk("rsp_err", 32'(rsp_err), 32'(m_re));
        chk("rsp_rdata", rsp_rdata, m_rd);
        chk("bus_hang", 32'(bus_hang), 32'(m_hang));
        chk("const_ctrl", 32'({HBURST, HMASTLOCK, HPROT}), 32'h0000_0003);
        if (m_phase == 1) begin
            chk("HADDR", HADDR, m_addr);
            chk("HSIZE", 32'(HSIZE), 32'(m_size));
            chk("HWRITE", 32'(HWRITE), 32'(m_write));
        end
        if (m_phase == 2) chk("HWDATA", HWDATA, exp_wd(m_wdata, m_size));
    end

    // ---------------- slave responder ----------------------------------------
    int          sl_waits = 0;
    logic        sl_err   = 1'b0;
    logic [31:0] sl_rdata = 32'd0;
    logic        sl_prev_addr = 1'b0;
    logic        sl_in_data   = 1'b0;
    int          sl_remain    = 0;

    always @(posedge HCLK) begin
        #1;
        if (!HRESETn) begin
            sl_prev_addr = 1'b0; sl_in_data = 1'b0;
            HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        end else begin
            if (sl_in_data && HREADY) sl_in_data = 1'b0;
            if (sl_prev_addr) begin
                sl_in_data = 1'b1;
                sl_remain  = sl_waits;
            end
            if (sl_in_data) begin
                if (sl_remain > 0) begin
                    HREADY = 1'b0;
                    HRESP  = sl_err && (sl_remain == 1);
                    HRDATA = 32'hBAD0_BAD0;
                    sl_remain--;
                end else begin
                    HREADY = 1'b1;
                    HRESP  = sl_err;
                    HRDATA = sl_rdata;
                end
            end else begin
                HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
            end
            sl_prev_addr = (HTRANS == 2'b10) && HREADY;
        end
    end

    // ---------------- stimulus -----------------------------------------------
    // Called #1 after a rising edge; returns #1 after the edge that raised rsp_valid.
    task automatic send(input logic w, input logic [31:0] a, input logic [2:0] s,
                        input logic [31:0] d, output int lat, output logic e,
                        output logic [31:0] rd, output logic [31:0] hw);
        int b;
        b = 0;
        while (!cmd_ready && b < 50) begin
            @(posedge HCLK); #1; b++;
        end
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        lat = 1; hw = 32'd0;
        while (!rsp_valid && lat < 100) begin
            hw = HWDATA;
            @(posedge HCLK); #1;
            lat++;
        end
        if (!rsp_valid) begin
            n_tests++; n_fail++;
            $display("FAIL rsp_timeout: no rsp_valid within %0d cycles for addr %08h", lat, a);
        end
        e  = rsp_err;
        rd = rsp_rdata;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          lat;
        logic        e;
        logic [31:0] rd;
        logic [31:0] hw;
        int          seen;

        repeat (3) @(posedge HCLK);
        #1;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_bus", {HTRANS, HSIZE, HWRITE, 26'd0}, 32'd0);
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_rsp", {rsp_valid, rsp_err, bus_hang, 29'd0}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        HRESETn = 1'b1;
        @(posedge HCLK); #1;

        // T1: zero-wait word write, cycle-exact.
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0010;
        cmd_size = 3'd2; cmd_wdata = 32'hDEAD_BEEF;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        chk("T1_c1_htrans", 32'(HTRANS), 32'd2);
        chk("T1_c1_haddr", HADDR, 32'h4000_0010);
        @(posedge HCLK); #1;
        chk("T1_c2_htrans", 32'(HTRANS), 32'd0);
        chk("T1_c2_hwdata", HWDATA, 32'hDEAD_BEEF);
        chk("T1_c2_rsp", 32'(rsp_valid), 32'd0);
        @(posedge HCLK); #1;
        chk("T1_c3_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("T1_c3_rsp_err", 32'(rsp_err), 32'd0);
        chk("T1_c3_rdata", rsp_rdata, 32'd0);
        @(posedge HCLK); #1;
        chk("T1_c4_rsp_clear", 32'(rsp_valid), 32'd0);

        // T2: byte read with two wait states; plus halfword read alignment.
        sl_waits = 2; sl_rdata = 32'h1234_5678;
        send(1'b0, 32'h4000_0013, 3'd0, 32'd0, lat, e, rd, hw);
        chk("T2_latency", 32'(lat), 32'd5);
        chk("T2_rdata", rd, 32'h0000_0012);
        chk("T2_err", 32'(e), 32'd0);
        sl_waits = 0; sl_rdata = 32'hAABB_CCDD;
        send(1'b0, 32'h4000_0002, 3'd1, 32'd0, lat, e, rd, hw);
        chk("T2b_latency", 32'(lat), 32'd3);
        chk("T2b_rdata", rd, 32'h0000_AABB);
        send(1'b0, 32'h4000_0001, 3'd0, 32'd0, lat, e, rd, hw);
        chk("T2c_rdata", rd, 32'h0000_00CC);

        // Lane replication on narrow writes.
        send(1'b1, 32'h4000_0021, 3'd0, 32'h0000_00A5, lat, e, rd, hw);
        chk("W_byte_hwdata", hw, 32'hA5A5_A5A5);
        send(1'b1, 32'h4000_0022, 3'd1, 32'hFFFF_1234, lat, e, rd, hw);
        chk("W_half_hwdata", hw, 32'h1234_1234);

        // T3: locally rejected commands.
        send(1'b1, 32'h4000_0001, 3'd1, 32'h0000_5555, lat, e, rd, hw);
        chk("T3_half_mis_lat", 32'(lat), 32'd1);
        chk("T3_half_mis_err", 32'(e), 32'd1);
        send(1'b0, 32'h4000_0000, 3'd3, 32'd0, lat, e, rd, hw);
        chk("T3_size3_lat", 32'(lat), 32'd1);
        chk("T3_size3_err", 32'(e), 32'd1);
        send(1'b0, 32'h4000_0002, 3'd2, 32'd0, lat, e, rd, hw);
        chk("T3_word_mis_err", 32'(e), 32'd1);
        chk("T3_word_mis_rd", rd, 32'd0);

        // T4: two-cycle slave ERROR response.
        sl_waits = 1; sl_err = 1'b1; sl_rdata = 32'h55AA_55AA;
        send(1'b0, 32'h4000_0030, 3'd2, 32'd0, lat, e, rd, hw);
        chk("T4_latency", 32'(lat), 32'd4);
        chk("T4_err", 32'(e), 32'd1);
        chk("T4_rdata", rd, 32'd0);
        chk("T4_no_hang", 32'(bus_hang), 32'd0);
        sl_err = 1'b0;

        // T5: watchdog fires after four data-phase wait cycles and sticks.
        sl_waits = 6;
        send(1'b1, 32'h4000_0040, 3'd2, 32'h0BAD_F00D, lat, e, rd, hw);
        chk("T5_latency", 32'(lat), 32'd9);
        chk("T5_err", 32'(e), 32'd0);
        chk("T5_hang", 32'(bus_hang), 32'd1);
        sl_waits = 0; sl_rdata = 32'hCAFE_F00D;
        send(1'b0, 32'h4000_0044, 3'd2, 32'd0, lat, e, rd, hw);
        chk("T5_rdata_after", rd, 32'hCAFE_F00D);
        chk("T5_hang_sticky", 32'(bus_hang), 32'd1);

        // T6: back-to-back commands, then reset during the second address phase.
        @(posedge HCLK); #1;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h4000_0020;
        cmd_size = 3'd2; cmd_wdata = 32'h1111_1111;
        @(posedge HCLK); #1;
        cmd_write = 1'b0; cmd_addr = 32'h4000_0024; cmd_wdata = 32'd0;
        seen = 0;
        while (!rsp_valid && seen < 20) begin
            @(posedge HCLK); #1; seen++;
        end
        chk("T6_rsp_seen", 32'(rsp_valid), 32'd1);
        chk("T6_ready_on_rsp", 32'(cmd_ready), 32'd1);
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        chk("T6_b2b_htrans", 32'(HTRANS), 32'd2);
        chk("T6_b2b_haddr", HADDR, 32'h4000_0024);
        #2;
        HRESETn = 1'b0;
        #1;
        chk("T6_rst_htrans", 32'(HTRANS), 32'd0);
        chk("T6_rst_haddr", HADDR, 32'd0);
        chk("T6_rst_flags", {rsp_valid, rsp_err, bus_hang, cmd_ready, 28'd0}, 32'h1000_0000);
        chk("T6_rst_hwdata", HWDATA, 32'd0);
        @(posedge HCLK); @(posedge HCLK); #1;
        HRESETn = 1'b1;
        seen = 0;
        repeat (5) begin
            @(posedge HCLK); #1;
            if (rsp_valid) seen++;
        end
        chk("T6_no_rsp_after_rst", 32'(seen), 32'd0);

        @(posedge HCLK); #1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
